// File: rtl/rectangle128_ctrl.sv
// Top-level sequencer for the RECTANGLE128 core.
// Latches a 128-bit key, runs the sub-key generator for one schedule pass, then
// serves blocks: it reads the 26 sub-keys from sub-key memory and drives the round
// datapath through NROUNDS rounds plus a final key addition.
//
// Ports:
//   Clk, RstN        clock, asynchronous active-low reset
//   key_load/key_in  key request and value; key_in_ready is the accept strobe
//   key_ready        sub-key memory holds a complete schedule
//   kg_*             sub-key generator restart, enable and latched key halves
//   in_valid/ready   plaintext handshake
//   out_valid/ready  ciphertext handshake
//   mem_re/raddr     sub-key memory read port (1-cycle latency)
//   dp_*             datapath strobes and round index
//   busy             sequencer is neither idle nor waiting for a block
module rectangle128_ctrl #(
    parameter int unsigned NROUNDS   = 25,
    parameter int unsigned KG_CYCLES = 27,
    parameter int unsigned AW        = 5
) (
    input  logic          Clk,
    input  logic          RstN,
    input  logic          key_load,
    input  logic [127:0]  key_in,
    output logic          key_in_ready,
    output logic          key_ready,
    output logic          kg_rst_n,
    output logic          kg_enable,
    output logic [63:0]   kg_key0,
    output logic [63:0]   kg_key1,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    output logic          dp_load,
    output logic          dp_round_en,
    output logic [AW-1:0] dp_round_idx,
    output logic          dp_final,
    output logic          busy
);

    localparam logic [AW-1:0] KgLast    = AW'(KG_CYCLES - 1);
    localparam logic [AW-1:0] RoundLast = AW'(NROUNDS);

    typedef enum logic [2:0] {
        StIdle,
        StKclr,
        StKgen,
        StReady,
        StRun,
        StHold
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] kg_cnt_q, kg_cnt_d;
    logic [AW-1:0] round_q, round_d;
    logic [63:0]   key0_q, key1_q;
    logic          key_accept;

    // Gated with RstN so every output reads 0 while reset is held.
    assign key_in_ready = RstN && ((state_q == StIdle) || (state_q == StReady));
    assign key_accept   = key_load && key_in_ready;
    // A key request in the same READY cycle takes priority over a block.
    assign in_ready     = (state_q == StReady) && !key_load;
    assign busy         = (state_q != StIdle) && (state_q != StReady);
    assign kg_rst_n     = RstN && (state_q != StKclr);
    assign kg_key0      = key0_q;
    assign kg_key1      = key1_q;

    always_comb begin
        state_d      = state_q;
        kg_cnt_d     = kg_cnt_q;
        round_d      = round_q;
        key_ready    = 1'b0;
        kg_enable    = 1'b0;
        out_valid    = 1'b0;
        mem_re       = 1'b0;
        mem_raddr    = '0;
        dp_load      = 1'b0;
        dp_round_en  = 1'b0;
        dp_round_idx = '0;
        dp_final     = 1'b0;

        case (state_q)
            StIdle: begin
                if (key_accept) state_d = StKclr;
            end
            StKclr: begin
                kg_cnt_d = '0;
                state_d  = StKgen;
            end
            StKgen: begin
                kg_enable = 1'b1;
                if (kg_cnt_q == KgLast) begin
                    kg_cnt_d = '0;
                    state_d  = StReady;
                end else begin
                    kg_cnt_d = kg_cnt_q + AW'(1);
                end
            end
            StReady: begin
                key_ready = 1'b1;
                if (key_accept) begin
                    state_d = StKclr;
                end else if (in_valid && in_ready) begin
                    // Address sub-key 0 now so it is on the bus for round 0.
                    dp_load = 1'b1;
                    mem_re  = 1'b1;
                    round_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                key_ready = 1'b1;
                if (round_q == RoundLast) begin
                    dp_final     = 1'b1;
                    dp_round_idx = RoundLast;
                    state_d      = StHold;
                end else begin
                    dp_round_en  = 1'b1;
                    dp_round_idx = round_q;
                    mem_re       = 1'b1;
                    mem_raddr    = round_q + AW'(1);
                    round_d      = round_q + AW'(1);
                end
            end
            StHold: begin
                key_ready = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = StReady;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q  <= StIdle;
            kg_cnt_q <= '0;
            round_q  <= '0;
            key0_q   <= '0;
            key1_q   <= '0;
        end else begin
            state_q  <= state_d;
            kg_cnt_q <= kg_cnt_d;
            round_q  <= round_d;
            if (key_accept) begin
                key0_q <= key_in[63:0];
                key1_q <= key_in[127:64];
            end
        end
    end

endmodule

// File: tb/tb_rectangle128_ctrl.sv
// Self-checking bench for rectangle128_ctrl. The reference derives every expected
// output from the cycle numbers at which a key and a block were accepted.
module tb_rectangle128_ctrl;

    localparam int NR = 25;
    localparam int KG = 27;

    logic         clk;
    logic         rst_n;
    logic         key_load;
    logic [127:0] key_in;
    logic         key_in_ready;
    logic         key_ready;
    logic         kg_rst_n;
    logic         kg_enable;
    logic [63:0]  kg_key0;
    logic [63:0]  kg_key1;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic         mem_re;
    logic [4:0]   mem_raddr;
    logic         dp_load;
    logic         dp_round_en;
    logic [4:0]   dp_round_idx;
    logic         dp_final;
    logic         busy;

    rectangle128_ctrl dut (
        .Clk          (clk),
        .RstN         (rst_n),
        .key_load     (key_load),
        .key_in       (key_in),
        .key_in_ready (key_in_ready),
        .key_ready    (key_ready),
        .kg_rst_n     (kg_rst_n),
        .kg_enable    (kg_enable),
        .kg_key0      (kg_key0),
        .kg_key1      (kg_key1),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mem_re       (mem_re),
        .mem_raddr    (mem_raddr),
        .dp_load      (dp_load),
        .dp_round_en  (dp_round_en),
        .dp_round_idx (dp_round_idx),
        .dp_final     (dp_final),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: cycle of last key / block acceptance.
    int           cyc      = 0;
    int           k_at     = 0;
    int           t_at     = 0;
    bit           k_valid  = 1'b0;
    bit           blk_live = 1'b0;
    logic [127:0] m_key    = '0;

    task automatic model_step();
        int d, e;
        bit kclr, kgen, kready, run, hold, rdy;
        bit ex_kir, ex_ir, ex_load, ex_ren, ex_fin;
        logic [4:0] ex_addr, ex_idx;
        if (!rst_n) begin
            k_valid  = 1'b0;
            blk_live = 1'b0;
            m_key    = '0;
        end
        d       = cyc - k_at;
        e       = cyc - t_at;
        kclr    = k_valid && d == 1;
        kgen    = k_valid && d >= 2 && d <= KG + 1;
        kready  = k_valid && d >= KG + 2;
        run     = blk_live && e >= 1 && e <= NR + 1;
        hold    = blk_live && e >= NR + 2;
        rdy     = kready && !blk_live;
        ex_kir  = rst_n && (!k_valid || rdy);
        ex_ir   = rdy && !key_load;
        ex_load = ex_ir && in_valid;
        ex_ren  = run && e <= NR;
        ex_fin  = run && e == NR + 1;
        ex_addr = ex_ren ? 5'(e) : 5'd0;
        ex_idx  = ex_ren ? 5'(e - 1) : (ex_fin ? 5'(NR) : 5'd0);

        check_eq("key_in_ready", key_in_ready, ex_kir);
        check_eq("key_ready", key_ready, kready);
        check_eq("kg_rst_n", kg_rst_n, rst_n && !kclr);
        check_eq("kg_enable", kg_enable, kgen);
        check_eq("kg_key0", kg_key0, m_key[63:0]);
        check_eq("kg_key1", kg_key1, m_key[127:64]);
        check_eq("in_ready", in_ready, ex_ir);
        check_eq("out_valid", out_valid, hold);
        check_eq("mem_re", mem_re, ex_load || ex_ren);
        check_eq("mem_raddr", mem_raddr, ex_addr);
        check_eq("dp_load", dp_load, ex_load);
        check_eq("dp_round_en", dp_round_en, ex_ren);
        check_eq("dp_round_idx", dp_round_idx, ex_idx);
        check_eq("dp_final", dp_final, ex_fin);
        check_eq("busy", busy, kclr || kgen || run || hold);

        if (ex_kir && key_load) begin
            k_at    = cyc;
            k_valid = 1'b1;
            m_key   = key_in;
        end
        if (ex_load) begin
            blk_live = 1'b1;
            t_at     = cyc;
        end
        if (hold && out_ready) blk_live = 1'b0;
        cyc++;
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call with key_load low; waits for a READY cycle.
    task automatic wait_in_ready(input int budget);
        int n = 0;
        bit timed_out;
        while (in_ready !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        timed_out = (in_ready !== 1'b1);
        check_eq("wait_in_ready", 128'(timed_out), 128'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;

        // Key 0 from IDLE.
        step(1);
        key_load = 1'b1;
        key_in   = '0;
        step(1);
        key_load = 1'b0;
        wait_in_ready(60);

        // Block with out_ready held low 10 cycles in HOLD.
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(36);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step(2);
        in_valid = 1'b0;
        step(30);
        wait_in_ready(60);

        // Key and block in the same READY cycle: the key wins.
        key_load = 1'b1;
        in_valid = 1'b1;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        step(1);
        key_load = 1'b0;
        in_valid = 1'b0;
        wait_in_ready(60);

        // Key request during round 12 must be ignored.
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(12);
        key_load = 1'b1;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        step(1);
        key_load = 1'b0;
        wait_in_ready(60);

        // Asynchronous reset at round 7.
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(7);
        #2 rst_n = 1'b0;
        #1 check_eq("reset_outputs_zero",
                    {key_in_ready, key_ready, kg_rst_n, kg_enable, kg_key0, kg_key1, in_ready,
                     out_valid, mem_re, mem_raddr, dp_load, dp_round_en, dp_round_idx, dp_final,
                     busy}, '0);
        step(2);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        step(10);
        in_valid = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            key_load  = ($urandom_range(0, 49) == 0);
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) == 0);
            step(1);
        end
        key_load = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
